load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter XLEN, 32, data path width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Port clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 Port valid_i  input  1  load request from execute stage.
REQ-006 Port funct3_i  input  3  load type.
REQ-007 Port addr_i  input  ADDR_W  byte address.
REQ-008 Port flush_i  input  1  pipeline flush; abandons the in-flight load.
REQ-009 Port ready_o  output  1  unit accepts a request this cycle.
REQ-010 Port mem_req_o  output  1  memory request.
REQ-011 Port mem_addr_o  output  ADDR_W  addr_i aligned down to XLEN/8 bytes.
REQ-012 Port mem_be_o  output  XLEN/8  byte enables of accessed lanes.
REQ-013 Port mem_gnt_i  input  1  memory accepted request.
REQ-014 Port mem_rvalid_i  input  1  read data valid.
REQ-015 Port mem_rdata_i  input  XLEN  read data.
REQ-016 Port mem_err_i  input  1  bus error, qualified by mem_rvalid_i.
REQ-017 Port data_o  output  XLEN  extended load result.
REQ-018 Port valid_o  output  1  one-cycle result strobe.
REQ-019 Port exc_o  output  1  one-cycle exception strobe; exc_cause_o valid with it.
REQ-020 Port exc_cause_o  output  2  00 illegal funct3, 01 misaligned, 10 access fault.

Function
REQ-021 funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU legal only when XLEN=64; all others illegal.
REQ-022 FSM states IDLE, REQ, WAIT, DRAIN, RESP; ready_o=1 only in IDLE with flush_i=0.
REQ-023 IDLE: valid_i&ready_o with legal, aligned request -> capture funct3, lane offset, addr; go REQ.
REQ-024 IDLE: illegal funct3 or misalignment (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0) -> exc_o pulse next cycle, cause 00/01 (illegal wins), no memory request, stay IDLE.
REQ-025 REQ: mem_req_o=1, mem_addr_o/mem_be_o held stable until mem_gnt_i; on grant -> WAIT; flush_i before grant -> IDLE, no request completes.
REQ-026 WAIT: mem_rvalid_i -> RESP, registering data; flush_i -> DRAIN.
REQ-027 DRAIN: discard next mem_rvalid_i, then IDLE; no valid_o, no exc_o.
REQ-028 RESP: valid_o=1 (or exc_o=1 cause 10 if captured mem_err_i) for exactly one cycle -> IDLE; flush_i in RESP suppresses both strobes.
REQ-029 Minimum latency: accept at T, grant at T+1, rvalid at T+2 -> valid_o at T+3.
REQ-030 Result: select lanes at byte offset addr[log2(XLEN/8)-1:0]; signed types sign-extend, unsigned zero-extend to XLEN.
REQ-031 mem_be_o: size-wide contiguous mask shifted by lane offset (e.g. LH at offset 2, XLEN=32 -> 4'b1100).
REQ-032 mem_rvalid_i in IDLE/REQ SHALL be ignored; at most one load outstanding.

Reset
REQ-033 rstn_i low SHALL immediately force IDLE, mem_req_o=0, valid_o=0, exc_o=0, data_o=0, exc_cause_o=0, mem_be_o=0, mem_addr_o=0, regardless of state; in-flight load is lost.
REQ-034 First acceptance possible on the first clock edge after rstn_i deasserts.

Structure
REQ-035 Package load_pkg SHALL hold funct3 constants, exc_cause codes, and the state type.
REQ-036 Combinational sub-module load_align SHALL perform lane selection and sign/zero extension; load_unit instantiates it.

Verification
REQ-037 XLEN=32, LB addr 0x103, rdata 0x80FF_FF00 -> mem_be_o 4'b1000, data_o 0xFFFF_FF80, valid_o at T+3.
REQ-038 XLEN=32, LHU addr 0x102, rdata 0x8001_1234 -> data_o 0x0000_8001; LH addr 0x101 -> exc_o, cause 01, mem_req_o stays 0.
REQ-039 Grant delayed 4 cycles -> mem_req_o/mem_addr_o/mem_be_o stable all 4 cycles, valid_o exactly once.
REQ-040 flush_i in WAIT, rvalid 2 cycles later -> no valid_o, ready_o returns cycle after rvalid.
REQ-041 XLEN=64 LWU addr 0x4, rdata 0xF000_0000_0000_0000 -> data_o 0x0000_0000_F000_0000; XLEN=32 funct3 011 -> exc_o cause 00.
REQ-042 rstn_i low mid-WAIT -> all outputs 0 asynchronously; stray rvalid after reset ignored.

Source files
------------

// File: rtl/load_pkg.sv
`timescale 1ns/1ps
// load_pkg: shared definitions for the load unit.
//   - funct3 encodings of the RISC-V style load instructions
//   - exception cause codes reported on exc_cause_o
//   - FSM state type
//   - helpers that classify a funct3 (legality, size mask, alignment)
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_FAULT    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } load_state_e;

  // LD and LWU only exist on a 64-bit data path.
  function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      F3_LD, F3_LWU:                       ok = (xlen == 32'sd64);
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Contiguous byte mask of the access width, anchored at lane 0.
  function automatic logic [7:0] f3_byte_mask(input logic [2:0] f3);
    logic [7:0] m;
    case (f3)
      F3_LB, F3_LBU:  m = 8'h01;
      F3_LH, F3_LHU:  m = 8'h03;
      F3_LW, F3_LWU:  m = 8'h0F;
      F3_LD:          m = 8'hFF;
      default:        m = 8'h00;
    endcase
    return m;
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] addr_lo);
    logic mis;
    case (f3)
      F3_LH, F3_LHU:  mis = addr_lo[0];
      F3_LW, F3_LWU:  mis = (addr_lo[1:0] != 2'b00);
      F3_LD:          mis = (addr_lo != 3'b000);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
`timescale 1ns/1ps
// load_align: combinational lane selection and sign/zero extension of a
// load result.
//   i_rdata  : raw bus word
//   i_funct3 : load type
//   i_off    : byte offset of the accessed lane inside the word
//   o_data   : extended result, XLEN bits
module load_align
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  i_rdata,
  input  logic [2:0]       i_funct3,
  input  logic [OFF_W-1:0] i_off,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_shifted;

  // Bring the addressed lane down to bit 0.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  // Extend the selected lane to the full data width.
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = XLEN'($signed(w_shifted[7:0]));
      F3_LH:   o_data = XLEN'($signed(w_shifted[15:0]));
      F3_LW:   o_data = XLEN'($signed(w_shifted[31:0]));
      F3_LBU:  o_data = XLEN'(w_shifted[7:0]);
      F3_LHU:  o_data = XLEN'(w_shifted[15:0]);
      F3_LWU:  o_data = XLEN'(w_shifted[31:0]);
      F3_LD:   o_data = w_shifted;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
`timescale 1ns/1ps
// load_unit: issues one aligned memory read per load, extends the result
// and reports illegal / misaligned / bus-fault exceptions.
//   clk_i, rstn_i          : clock, async active-low reset
//   valid_i/funct3_i/addr_i: load request from execute, ready_o accepts it
//   flush_i                : abandons the load in flight
//   mem_req_o/addr_o/be_o  : memory request, held until mem_gnt_i
//   mem_rvalid_i/rdata/err : memory response
//   data_o, valid_o        : load result and one-cycle strobe
//   exc_o, exc_cause_o     : one-cycle exception strobe and its cause
module load_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_err_i,
  output logic [XLEN-1:0]   data_o,
  output logic              valid_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  load_state_e       r_state;
  load_state_e       w_state_nxt;

  logic              w_ready;
  logic              w_legal;
  logic              w_misal;
  logic              w_accept;
  logic              w_good;
  logic              w_bad;
  logic              w_capture;
  logic [OFF_W-1:0]  w_off;
  logic [NB-1:0]     w_be;
  logic [ADDR_W-1:0] w_addr_al;
  logic [XLEN-1:0]   w_aligned;

  logic [2:0]        r_f3;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [XLEN-1:0]   r_data;
  logic [1:0]        r_cause;
  logic              r_err;
  logic              r_exc_now;

  assign w_off     = addr_i[OFF_W-1:0];
  assign w_ready   = (r_state == ST_IDLE) && !flush_i;
  assign w_legal   = f3_legal(funct3_i, XLEN);
  assign w_misal   = f3_misaligned(funct3_i, addr_i[2:0]);
  assign w_accept  = valid_i && w_ready;
  assign w_good    = w_accept && w_legal && !w_misal;
  assign w_bad     = w_accept && !(w_legal && !w_misal);
  assign w_be      = NB'(f3_byte_mask(funct3_i)) << w_off;
  assign w_addr_al = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  // Response is only kept when it arrives in WAIT and is not being flushed.
  assign w_capture = (r_state == ST_WAIT) && mem_rvalid_i && !flush_i;

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .i_rdata  (mem_rdata_i),
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .o_data   (w_aligned)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_good) w_state_nxt = ST_REQ;
        else        w_state_nxt = ST_IDLE;
      end
      ST_REQ: begin
        // Granted in the same cycle as a flush: the read is already on
        // the bus, so its response still has to be swallowed.
        if (mem_gnt_i)    w_state_nxt = flush_i ? ST_DRAIN : ST_WAIT;
        else if (flush_i) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_REQ;
      end
      ST_WAIT: begin
        // Response coinciding with a flush is consumed and dropped here.
        if (mem_rvalid_i) w_state_nxt = flush_i ? ST_IDLE : ST_RESP;
        else if (flush_i) w_state_nxt = ST_DRAIN;
        else              w_state_nxt = ST_WAIT;
      end
      ST_DRAIN: begin
        if (mem_rvalid_i) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_DRAIN;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, response capture and exception bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_f3      <= 3'b000;
      r_off     <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_data    <= '0;
      r_cause   <= 2'b00;
      r_err     <= 1'b0;
      r_exc_now <= 1'b0;
    end else begin
      r_exc_now <= w_bad;
      if (w_good) begin
        r_f3   <= funct3_i;
        r_off  <= w_off;
        r_addr <= w_addr_al;
        r_be   <= w_be;
      end
      // An illegal funct3 is reported even if the address is also misaligned.
      if (w_bad) begin
        r_cause <= w_legal ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
      end else if (w_capture && mem_err_i) begin
        r_cause <= CAUSE_FAULT;
      end
      if (w_capture) begin
        r_data <= w_aligned;
        r_err  <= mem_err_i;
      end
    end
  end

  assign ready_o     = w_ready;
  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign data_o      = r_data;
  assign exc_cause_o = r_cause;
  // A flush during RESP must still be able to kill the strobe that cycle.
  assign valid_o     = (r_state == ST_RESP) && !r_err && !flush_i;
  assign exc_o       = r_exc_now || ((r_state == ST_RESP) && r_err && !flush_i);

endmodule

// File: tb/tb_load_unit.sv
`timescale 1ns/1ps
module tb_load_unit;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        valid, flush, gnt, rvalid, err;
  logic [2:0]  f3;
  logic [31:0] addr, rdata;
  logic        ready, mreq, vo, exc;
  logic [31:0] maddr, data;
  logic [3:0]  mbe;
  logic [1:0]  cause;

  logic        d_valid, d_flush, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_f3;
  logic [31:0] d_addr;
  logic [63:0] d_rdata;
  logic        d_ready, d_mreq, d_vo, d_exc;
  logic [31:0] d_maddr;
  logic [63:0] d_data;
  logic [7:0]  d_mbe;
  logic [1:0]  d_cause;

  load_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .funct3_i(f3), .addr_i(addr),
    .flush_i(flush), .ready_o(ready), .mem_req_o(mreq), .mem_addr_o(maddr),
    .mem_be_o(mbe), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .mem_err_i(err), .data_o(data), .valid_o(vo), .exc_o(exc), .exc_cause_o(cause));

  load_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(d_valid), .funct3_i(d_f3), .addr_i(d_addr),
    .flush_i(d_flush), .ready_o(d_ready), .mem_req_o(d_mreq), .mem_addr_o(d_maddr),
    .mem_be_o(d_mbe), .mem_gnt_i(d_gnt), .mem_rvalid_i(d_rvalid), .mem_rdata_i(d_rdata),
    .mem_err_i(d_err), .data_o(d_data), .valid_o(d_vo), .exc_o(d_exc), .exc_cause_o(d_cause));

  int errors = 0;
  int checks = 0;

  int          ob_k, ob_nval, ob_nexc, ob_at;
  logic [31:0] ob_data;
  logic [1:0]  ob_cause;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f, input int xlen);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      3'd3:       return (xlen == 64) ? 8 : 0;
      3'd6:       return (xlen == 64) ? 4 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] m_result(input logic [2:0] f, input logic [31:0] a,
                                           input logic [63:0] rd, input int xlen);
    int nb, off;
    logic [63:0] v, mask;
    nb   = m_size(f, xlen);
    off  = int'(a[2:0]) % (xlen / 8);
    v    = rd >> (8 * off);
    mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if ((f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd3) && v[8*nb-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] f, input logic [31:0] a, input int xlen);
    int nb, off;
    nb  = m_size(f, xlen);
    off = int'(a[2:0]) % (xlen / 8);
    return 8'(((1 << nb) - 1) << off);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic obs_clear();
    ob_k = 0; ob_nval = 0; ob_nexc = 0; ob_at = -1; ob_data = '0; ob_cause = '0;
  endtask

  task automatic obs();
    if (vo === 1'b1) begin ob_nval++; ob_at = ob_k; ob_data = data; ob_cause = cause; end
    if (exc === 1'b1) begin ob_nexc++; ob_at = ob_k; ob_cause = cause; end
    ob_k++;
  endtask

  // Drives one legal load on the 32-bit unit; records what was observed.
  task automatic run_load32(input logic [2:0] tf, input logic [31:0] ta, input logic [31:0] trd,
                            input logic te, input int gd, input int rdl, input logic stray,
                            output int req_bad, output logic [31:0] a_seen,
                            output logic [3:0] be_seen, output int ready_back);
    req_bad = 0; a_seen = '0; be_seen = '0; ready_back = 0;
    obs_clear();
    valid = 1'b1; f3 = tf; addr = ta; #1;
    if (ready !== 1'b1) req_bad++;
    obs(); cyc();
    valid = 1'b0;
    for (int g = 0; g <= gd; g++) begin
      f3 = 3'($urandom); addr = $urandom;
      gnt = (g == gd); rvalid = stray ? 1'($urandom) : 1'b0; rdata = $urandom; err = 1'($urandom);
      #1;
      if (g == 0) begin a_seen = maddr; be_seen = mbe; end
      if (mreq !== 1'b1 || maddr !== a_seen || mbe !== be_seen) req_bad++;
      obs(); cyc();
    end
    gnt = 1'b0;
    for (int r = 0; r <= rdl; r++) begin
      rvalid = (r == rdl);
      rdata  = (r == rdl) ? trd : $urandom;
      err    = (r == rdl) ? te : 1'($urandom);
      #1;
      if (mreq !== 1'b0) req_bad++;
      obs(); cyc();
    end
    rvalid = 1'b0; err = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1; obs();
      if (j == 1) ready_back = int'(ready);
      cyc();
    end
  endtask

  // Drives one request that must be rejected; records the exception pulse.
  task automatic run_bad32(input logic [2:0] tf, input logic [31:0] ta,
                           output logic exc1, output logic [1:0] cause1,
                           output int mreq_any, output logic exc2, output logic ready2);
    mreq_any = 0;
    valid = 1'b1; f3 = tf; addr = ta; #1; cyc();
    valid = 1'b0; #1;
    exc1 = exc; cause1 = cause; if (mreq !== 1'b0) mreq_any++;
    cyc(); #1;
    exc2 = exc; ready2 = ready; if (mreq !== 1'b0) mreq_any++;
    cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    valid = 0; flush = 0; gnt = 0; rvalid = 0; err = 0; f3 = 0; addr = 0; rdata = 0;
    d_valid = 0; d_flush = 0; d_gnt = 0; d_rvalid = 0; d_err = 0; d_f3 = 0; d_addr = 0; d_rdata = 0;
    #1 rstn = 1'b0;
    #2;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %b expected 0", mreq); end
    checks++; if (vo !== 1'b0 || exc !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", vo, exc); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (maddr !== 32'h0 || mbe !== 4'h0) begin errors++; $display("FAIL reset_addr_be: got %h/%h expected 0/0", maddr, mbe); end
    checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", cause); end
    checks++; if ({d_mreq, d_vo, d_exc, d_data, d_mbe, d_maddr} !== '0) begin errors++; $display("FAIL reset_64: outputs not all zero"); end
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    cyc();
  endtask

  task automatic test_lb_signed();
    int rb, rback; logic [31:0] as; logic [3:0] bs;
    run_load32(3'b000, 32'h103, 32'h80FF_FF00, 1'b0, 0, 0, 1'b0, rb, as, bs, rback);
    checks++; if (bs !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b expected 1000", bs); end
    checks++; if (as !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h expected 100", as); end
    checks++; if (ob_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", ob_data); end
    checks++; if (ob_at !== 3 || ob_nval !== 1 || ob_nexc !== 0) begin errors++; $display("FAIL lb_latency: got at=%0d nval=%0d nexc=%0d expected 3/1/0", ob_at, ob_nval, ob_nexc); end
    checks++; if (rb !== 0 || rback !== 1) begin errors++; $display("FAIL lb_handshake: got bad=%0d ready=%0d expected 0/1", rb, rback); end
  endtask

  task automatic test_lhu_and_misaligned();
    int rb, rback, ma; logic [31:0] as; logic [3:0] bs; logic e1, e2, r2; logic [1:0] c1;
    run_load32(3'b101, 32'h102, 32'h8001_1234, 1'b0, 0, 0, 1'b0, rb, as, bs, rback);
    checks++; if (ob_data !== 32'h0000_8001 || bs !== 4'b1100) begin errors++; $display("FAIL lhu: got %h/%b expected 00008001/1100", ob_data, bs); end
    run_bad32(3'b001, 32'h101, e1, c1, ma, e2, r2);
    checks++; if (e1 !== 1'b1 || c1 !== 2'b01) begin errors++; $display("FAIL lh_misaligned: got exc=%b cause=%b expected 1/01", e1, c1); end
    checks++; if (ma !== 0 || e2 !== 1'b0 || r2 !== 1'b1) begin errors++; $display("FAIL lh_misaligned_after: got req=%0d exc=%b ready=%b expected 0/0/1", ma, e2, r2); end
  endtask

  task automatic test_grant_delay();
    int rb, rback; logic [31:0] as; logic [3:0] bs;
    run_load32(3'b010, 32'h0000_0AB4, 32'h1234_5678, 1'b0, 4, 1, 1'b1, rb, as, bs, rback);
    checks++; if (rb !== 0 || as !== 32'h0AB4 || bs !== 4'hF) begin errors++; $display("FAIL grant_delay_stable: got bad=%0d addr=%h be=%h expected 0/ab4/f", rb, as, bs); end
    checks++; if (ob_nval !== 1 || ob_at !== 8 || ob_data !== 32'h1234_5678) begin errors++; $display("FAIL grant_delay_result: got n=%0d at=%0d d=%h expected 1/8/12345678", ob_nval, ob_at, ob_data); end
  endtask

  task automatic test_flush();
    int nv; nv = 0;
    // flush while waiting for data
    valid = 1; f3 = 3'b010; addr = 32'h200; #1; cyc();
    valid = 0; gnt = 1; #1; cyc();
    gnt = 0; flush = 1; #1; nv += int'(vo) + int'(exc); cyc();
    flush = 0; #1; nv += int'(vo) + int'(exc);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_wait_drain: got ready=%b expected 0", ready); end
    cyc();
    rvalid = 1; rdata = $urandom; #1; nv += int'(vo) + int'(exc);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_wait_rvalid: got ready=%b expected 0", ready); end
    cyc();
    rvalid = 0; #1; nv += int'(vo) + int'(exc);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_wait_ready: got ready=%b expected 1", ready); end
    cyc(); #1; nv += int'(vo) + int'(exc); cyc();
    checks++; if (nv !== 0) begin errors++; $display("FAIL flush_wait_strobes: got %0d expected 0", nv); end
    // flush before grant
    valid = 1; f3 = 3'b000; addr = 32'h40; #1; cyc();
    valid = 0; flush = 1; #1; cyc();
    flush = 0; #1;
    checks++; if (mreq !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL flush_req: got req=%b ready=%b expected 0/1", mreq, ready); end
    rvalid = 1; cyc(); rvalid = 0; #1;
    checks++; if (vo !== 1'b0 || exc !== 1'b0) begin errors++; $display("FAIL flush_req_stray: got %b%b expected 00", vo, exc); end
    cyc();
    // flush during the result cycle
    valid = 1; f3 = 3'b010; addr = 32'h44; #1; cyc();
    valid = 0; gnt = 1; #1; cyc();
    gnt = 0; rvalid = 1; rdata = 32'h5; #1; cyc();
    rvalid = 0; flush = 1; #1;
    checks++; if (vo !== 1'b0 || exc !== 1'b0) begin errors++; $display("FAIL flush_resp: got %b%b expected 00", vo, exc); end
    cyc(); flush = 0; #1;
    checks++; if (vo !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL flush_resp_after: got vo=%b ready=%b expected 0/1", vo, ready); end
    cyc();
  endtask

  task automatic test_illegal();
    int ma; logic e1, e2, r2; logic [1:0] c1;
    logic [2:0]  tfs [3] = '{3'b011, 3'b110, 3'b111};
    logic [31:0] tas [3] = '{32'h100, 32'h100, 32'h101};
    for (int i = 0; i < 3; i++) begin
      run_bad32(tfs[i], tas[i], e1, c1, ma, e2, r2);
      checks++; if (e1 !== 1'b1 || c1 !== 2'b00 || ma !== 0 || e2 !== 1'b0) begin errors++; $display("FAIL illegal_%0d: got exc=%b cause=%b req=%0d exc2=%b expected 1/00/0/0", i, e1, c1, ma, e2); end
    end
    run_bad32(3'b011, 32'h101, e1, c1, ma, e2, r2);
    checks++; if (c1 !== 2'b00) begin errors++; $display("FAIL illegal_wins: got cause=%b expected 00", c1); end
  endtask

  task automatic test_xlen64();
    logic [2:0]  tfs [4] = '{3'b110, 3'b010, 3'b011, 3'b000};
    logic [31:0] tas [4] = '{32'h4, 32'h4, 32'h8, 32'h7};
    logic [63:0] trd [4];
    logic [63:0] exp;
    trd[0] = 64'hF000_0000_0000_0000; trd[1] = 64'hF000_0000_0000_0000;
    trd[2] = {$urandom, $urandom}; trd[3] = 64'h8012_3456_789A_BCDE;
    for (int i = 0; i < 4; i++) begin
      exp = m_result(tfs[i], tas[i], trd[i], 64);
      if (i == 0) exp = 64'h0000_0000_F000_0000;
      d_valid = 1; d_f3 = tfs[i]; d_addr = tas[i]; #1; cyc();
      d_valid = 0; d_gnt = 1; #1;
      checks++; if (d_mreq !== 1'b1 || d_mbe !== m_be(tfs[i], tas[i], 64)) begin errors++; $display("FAIL x64_be_%0d: got req=%b be=%h expected 1/%h", i, d_mreq, d_mbe, m_be(tfs[i], tas[i], 64)); end
      cyc();
      d_gnt = 0; d_rvalid = 1; d_rdata = trd[i]; #1; cyc();
      d_rvalid = 0; #1;
      checks++; if (d_vo !== 1'b1 || d_data !== exp) begin errors++; $display("FAIL x64_data_%0d: got vo=%b d=%h expected 1/%h", i, d_vo, d_data, exp); end
      cyc();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] tf; logic [31:0] ta, trd, as; logic te, e1, e2, r2; logic [3:0] bs; logic [1:0] c1, ec;
      int nb, gd, rdl, rb, rback, ma;
      tf = 3'($urandom_range(0, 7)); ta = $urandom; trd = $urandom;
      nb = m_size(tf, 32);
      if (nb != 0 && $urandom_range(0, 2) != 0) ta = ta & ~32'(nb - 1);
      if (nb == 0 || (ta % 32'(nb)) != 0) begin
        ec = (nb == 0) ? 2'b00 : 2'b01;
        run_bad32(tf, ta, e1, c1, ma, e2, r2);
        checks++; if (e1 !== 1'b1 || c1 !== ec || ma !== 0 || e2 !== 1'b0) begin errors++; $display("FAIL rand_bad_%0d: got exc=%b cause=%b req=%0d expected 1/%b/0", i, e1, c1, ma, ec); end
      end else begin
        te = ($urandom_range(0, 3) == 0); gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
        run_load32(tf, ta, trd, te, gd, rdl, 1'b1, rb, as, bs, rback);
        checks++; if (rb !== 0 || as !== (ta & ~32'h3) || bs !== 4'(m_be(tf, ta, 32)) || rback !== 1) begin errors++; $display("FAIL rand_req_%0d: got bad=%0d a=%h be=%b rdy=%0d expected 0/%h/%b/1", i, rb, as, bs, rback, ta & ~32'h3, 4'(m_be(tf, ta, 32))); end
        if (te) begin
          checks++; if (ob_nexc !== 1 || ob_nval !== 0 || ob_cause !== 2'b10 || ob_at !== 3 + gd + rdl) begin errors++; $display("FAIL rand_fault_%0d: got nexc=%0d nval=%0d cause=%b at=%0d expected 1/0/10/%0d", i, ob_nexc, ob_nval, ob_cause, ob_at, 3 + gd + rdl); end
        end else begin
          checks++; if (ob_nval !== 1 || ob_nexc !== 0 || ob_data !== 32'(m_result(tf, ta, {32'h0, trd}, 32)) || ob_at !== 3 + gd + rdl) begin errors++; $display("FAIL rand_load_%0d: got n=%0d d=%h at=%0d expected 1/%h/%0d", i, ob_nval, ob_data, ob_at, 32'(m_result(tf, ta, {32'h0, trd}, 32)), 3 + gd + rdl); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int rb, rback, ns; logic [31:0] as; logic [3:0] bs;
    run_load32(3'b010, 32'h300, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, rb, as, bs, rback);
    valid = 1; f3 = 3'b010; addr = 32'h304; #1; cyc();
    valid = 0; gnt = 1; #1; cyc();
    gnt = 0; #2; rstn = 1'b0; #1;
    checks++; if (mreq !== 1'b0 || maddr !== 32'h0 || mbe !== 4'h0) begin errors++; $display("FAIL async_rst_req: got %b/%h/%h expected 0/0/0", mreq, maddr, mbe); end
    checks++; if (data !== 32'h0 || vo !== 1'b0 || exc !== 1'b0 || cause !== 2'b00) begin errors++; $display("FAIL async_rst_out: got d=%h vo=%b exc=%b c=%b expected all 0", data, vo, exc, cause); end
    @(negedge clk) rstn = 1'b1;
    cyc();
    rvalid = 1; err = 1; rdata = $urandom; #1; cyc();
    rvalid = 0; err = 0; ns = 0;
    for (int j = 0; j < 3; j++) begin #1; ns += int'(vo) + int'(exc); cyc(); end
    checks++; if (ns !== 0 || ready !== 1'b1) begin errors++; $display("FAIL async_rst_stray: got strobes=%0d ready=%b expected 0/1", ns, ready); end
    // acceptance on the very first edge after release
    rstn = 1'b0; #2;
    @(negedge clk); rstn = 1'b1; valid = 1; f3 = 3'b000; addr = 32'h10;
    @(posedge clk); #1;
    valid = 0; gnt = 1; #1;
    checks++; if (mreq !== 1'b1 || maddr !== 32'h10) begin errors++; $display("FAIL first_accept: got req=%b addr=%h expected 1/10", mreq, maddr); end
    cyc();
    gnt = 0; rvalid = 1; rdata = 32'h0000_007F; #1; cyc();
    rvalid = 0; #1;
    checks++; if (vo !== 1'b1 || data !== 32'h7F) begin errors++; $display("FAIL first_accept_data: got vo=%b d=%h expected 1/7f", vo, data); end
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lb_signed();
    test_lhu_and_misaligned();
    test_grant_delay();
    test_flush();
    test_illegal();
    test_xlen64();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
